// File: rtl/pixel_frame_buffer.sv
// Double-buffered pixel frame store: one bank is read (front) while the other is
// written (back); a swap exchanges them once the serialiser is idle.
// Optional build macro PFB_CLEAR_EN: after each swap, hardware zero-fills the new
// back bank, one word per cycle; user writes are refused while it runs.
module pixel_frame_buffer #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_busy_i,
  input  logic              swap_req_i,
  output logic              swap_ack_o,
  output logic              clear_busy_o
);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int STAGES = 3;

  typedef enum logic {IDLE, PENDING} swap_state_e;

  swap_state_e       state_q, state_d;
  logic              bank_q;
  logic              swap_go;
  logic              swap_ack_q;

  // Bank select is the MSB of the RAM address, so the banks can never overlap.
  logic [DATA_W-1:0] mem [0:2*DEPTH-1];
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W:0]   rd_ptr_q;
  logic [ADDR_W:0]   wr_ptr;
  logic [DATA_W-1:0] wr_word;
  logic              wr_fire;
  logic [STAGES-1:0] vld_pipe;

`ifdef PFB_CLEAR_EN
  logic              clear_busy_q;
  logic [ADDR_W-1:0] clr_addr_q;

  // Zero-fill sweep over the new back bank, launched by the swap edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clear_busy_q <= 1'b0;
      clr_addr_q   <= '0;
    end else if (swap_go) begin
      clear_busy_q <= 1'b1;
      clr_addr_q   <= '0;
    end else if (clear_busy_q) begin
      clr_addr_q <= clr_addr_q + ADDR_W'(1);
      if (clr_addr_q == {ADDR_W{1'b1}}) clear_busy_q <= 1'b0;
    end
  end

  assign clear_busy_o = clear_busy_q;
  assign wr_ready_o   = !clear_busy_q;

  // Clear owns the write port while running; user writes are dropped.
  always_comb begin
    wr_fire = clear_busy_q | wr_en_i;
    wr_ptr  = {~bank_q, (clear_busy_q ? clr_addr_q : wr_addr_i)};
    wr_word = clear_busy_q ? '0 : wr_data_i;
  end
`else
  assign clear_busy_o = 1'b0;
  assign wr_ready_o   = 1'b1;

  // User writes always target the back bank.
  always_comb begin
    wr_fire = wr_en_i;
    wr_ptr  = {~bank_q, wr_addr_i};
    wr_word = wr_data_i;
  end
`endif

  // Swap FSM state and bank register; ack is the registered swap event.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bank_q     <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_q ^ swap_go;
      swap_ack_q <= swap_go;
    end
  end

  // A request swaps on its own edge when nothing blocks it, else waits in PENDING.
  always_comb begin
    state_d = state_q;
    swap_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap_req_i) begin
          if (!rd_busy_i && !clear_busy_o) swap_go = 1'b1;
          else                             state_d = PENDING;
        end
      end
      PENDING: begin
        if (!rd_busy_i && !clear_busy_o) begin
          swap_go = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign swap_ack_o = swap_ack_q;

  // Block RAM: read-first port so a write landing on the read word returns old data.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[wr_ptr] <= wr_word;
    ram_q <= mem[rd_ptr_q];
  end

  // Read pipeline: bank captured at the sampling edge, RAM read, output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], rd_en_i};
      if (rd_en_i)              rd_ptr_q  <= {bank_q, rd_addr_i};
      if (vld_pipe[STAGES-2])   rd_data_q <= ram_q;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = vld_pipe[STAGES-1];

endmodule
